// File: rtl/updn_counter_arbiter_if.sv
// Client/counter-side bundle for updn_counter_arbiter: per-requester command
// lanes, grant/completion status, and the strobe/feedback pair of the counter.
interface updn_counter_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 5
);
    logic [N-1:0]       Req;
    logic [2*N-1:0]     Cmd;
    logic [WIDTH*N-1:0] Arg;
    logic [N-1:0]       Gnt;
    logic [N-1:0]       Done;
    logic               Sat;
    logic [WIDTH-1:0]   Result;
    logic               Cnt_Load;
    logic               Cnt_Up;
    logic               Cnt_Down;
    logic [WIDTH-1:0]   Cnt_IN;
    logic [WIDTH-1:0]   Cnt_Value;
    logic               Cnt_High;
    logic               Cnt_Low;

    modport slave (
        input  Req, Cmd, Arg, Cnt_Value, Cnt_High, Cnt_Low,
        output Gnt, Done, Sat, Result, Cnt_Load, Cnt_Up, Cnt_Down, Cnt_IN
    );

    modport master (
        output Req, Cmd, Arg, Cnt_Value, Cnt_High, Cnt_Low,
        input  Gnt, Done, Sat, Result, Cnt_Load, Cnt_Up, Cnt_Down, Cnt_IN
    );
endinterface

// File: rtl/updn_counter_arbiter.sv
// Round-robin front end that shares one saturating up/down counter among N
// clients, turning LOAD / UP-by-k / DOWN-by-k commands into counter strobes.
module updn_counter_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    updn_counter_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_UP, OP_DOWN} op_t;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] rem;
    logic [PW-1:0]    ptr;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             sat;
    logic [WIDTH-1:0] result_hold;

    logic             any_req;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    ptr_next;
    logic [1:0]       cmd_sel;
    logic [WIDTH-1:0] arg_sel;
    logic             run;
    logic             step;
    logic             sat_hit;
    logic             finish;

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int j = 0; j < N; j++) begin
            idx = int'(ptr) + j;
            if (idx >= N) idx = idx - N;
            if (!any_req && bus.Req[idx]) begin
                any_req = 1'b1;
                winner  = PW'(idx);
            end
        end
    end

    assign ptr_next = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
    assign cmd_sel  = bus.Cmd[2*int'(winner) +: 2];
    assign arg_sel  = bus.Arg[WIDTH*int'(winner) +: WIDTH];

    // Strobes depend only on state, remaining steps and counter limits, so a
    // limit reached by the previous strobe suppresses the next one in time.
    assign run     = (state == RUN);
    assign sat_hit = run && (rem != '0) &&
                     (((op == OP_UP) && bus.Cnt_High) || ((op == OP_DOWN) && bus.Cnt_Low));
    assign step    = run && (rem != '0) && !sat_hit && ((op == OP_UP) || (op == OP_DOWN));
    assign finish  = (op == OP_NOP) || (op == OP_LOAD) || (rem == '0) || sat_hit ||
                     (step && (rem == WIDTH'(1)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            op          <= OP_NOP;
            rem         <= '0;
            ptr         <= '0;
            gnt         <= '0;
            done        <= '0;
            sat         <= 1'b0;
            result_hold <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= onehot(winner);
                        op    <= op_t'(cmd_sel);
                        rem   <= arg_sel;
                        ptr   <= ptr_next;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        gnt   <= '0;
                        done  <= gnt;
                        sat   <= sat_hit;
                        state <= DONE;
                    end else if (step) begin
                        rem <= rem - 1'b1;
                    end
                end
                DONE: begin
                    result_hold <= bus.Cnt_Value;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // During DONE the counter already reflects the final strobe, so Result
    // follows it live and is then held until the next completion.
    assign bus.Result   = (state == DONE) ? bus.Cnt_Value : result_hold;
    assign bus.Gnt      = gnt;
    assign bus.Done     = done;
    assign bus.Sat      = sat;
    assign bus.Cnt_Load = run && (op == OP_LOAD);
    assign bus.Cnt_Up   = step && (op == OP_UP);
    assign bus.Cnt_Down = step && (op == OP_DOWN);
    assign bus.Cnt_IN   = (run && (op == OP_LOAD)) ? rem : '0;
endmodule

// File: tb/tb_updn_counter_arbiter.sv
// Scoreboard bench for updn_counter_arbiter with a behavioural 5-bit
// saturating counter attached to its strobe outputs.
module tb_updn_counter_arbiter;
    localparam int N = 4;
    localparam int W = 5;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] result;
        logic         sat;
        int           nload;
        int           nup;
        int           ndown;
        int           lat;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] cnt = '0;

    item_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit abort_ok = 1'b0;

    updn_counter_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    updn_counter_arbiter #(.N(N), .WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.Cnt_Load)                     cnt <= bus.Cnt_IN;
        else if (bus.Cnt_Up && cnt != '1)     cnt <= cnt + 1'b1;
        else if (bus.Cnt_Down && cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign bus.Cnt_Value = cnt;
    assign bus.Cnt_High  = (cnt == '1);
    assign bus.Cnt_Low   = (cnt == '0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: strobe counting, grant order and completion checks.
    initial begin
        int cyc, g_cyc, nl, nu, nd;
        logic [N-1:0] gnt_prev;
        item_t it;
        cyc = 0; g_cyc = 0; nl = 0; nu = 0; nd = 0; gnt_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                nl = 0; nu = 0; nd = 0; gnt_prev = '0;
            end else begin
                if (bus.Cnt_Load) nl++;
                if (bus.Cnt_Up)   nu++;
                if (bus.Cnt_Down) nd++;
                if (int'(bus.Cnt_Load) + int'(bus.Cnt_Up) + int'(bus.Cnt_Down) > 1)
                    check("strobe_exclusive", 32'd1, 32'd0);
                if (bus.Gnt != '0 && gnt_prev == '0) begin
                    g_cyc = cyc;
                    if (q.size() != 0) check("gnt_order", 32'(bus.Gnt), 32'(q[0].gnt));
                    else if (!abort_ok) check("unexpected_gnt", 32'(bus.Gnt), 32'd0);
                end
                if (bus.Done != '0) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'(bus.Done), 32'd0);
                    end else begin
                        it = q.pop_front();
                        check("done_vec", 32'(bus.Done), 32'(it.gnt));
                        check("result",   32'(bus.Result), 32'(it.result));
                        check("sat",      32'(bus.Sat), 32'(it.sat));
                        check("n_load",   32'(nl), 32'(it.nload));
                        check("n_up",     32'(nu), 32'(it.nup));
                        check("n_down",   32'(nd), 32'(it.ndown));
                        check("latency",  32'(cyc - g_cyc), 32'(it.lat));
                    end
                    nl = 0; nu = 0; nd = 0;
                end
                gnt_prev = bus.Gnt;
            end
        end
    end

    function automatic item_t mk(input int i, input int res, input bit s,
                                 input int l, input int u, input int d, input int lat);
        item_t it;
        it.gnt = '0; it.gnt[i] = 1'b1;
        it.result = W'(res); it.sat = s;
        it.nload = l; it.nup = u; it.ndown = d; it.lat = lat;
        return it;
    endfunction

    task automatic wait_bit(input bit use_done, input int i, input int bound, input string name);
        int n;
        n = 0;
        while (!(use_done ? bus.Done[i] : bus.Gnt[i]) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check(name, 32'd0, 32'd1);
    endtask

    task automatic run_op(input int i, input logic [1:0] cmd, input int arg, input item_t it);
        q.push_back(it);
        bus.Cmd[2*i +: 2] = cmd;
        bus.Arg[W*i +: W] = W'(arg);
        bus.Req[i] = 1'b1;
        @(negedge clk);
        wait_bit(1'b0, i, 20, "gnt_timeout");
        bus.Req[i] = 1'b0;
        wait_bit(1'b1, i, 60, "done_timeout");
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.Req = '0; bus.Cmd = '0; bus.Arg = '0;
        @(negedge clk);
        check("reset_outputs",
              32'({bus.Gnt, bus.Done, bus.Sat, bus.Result, bus.Cnt_Load, bus.Cnt_Up, bus.Cnt_Down, bus.Cnt_IN}),
              32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 2'b01, 7,  mk(0, 7,  1'b0, 1, 0, 0, 1));
        run_op(1, 2'b01, 29, mk(1, 29, 1'b0, 1, 0, 0, 1));
        run_op(1, 2'b10, 5,  mk(1, 31, 1'b1, 0, 2, 0, 3));
        run_op(2, 2'b01, 3,  mk(2, 3,  1'b0, 1, 0, 0, 1));
        run_op(2, 2'b11, 2,  mk(2, 1,  1'b0, 0, 0, 2, 2));
        run_op(3, 2'b10, 0,  mk(3, 1,  1'b0, 0, 0, 0, 1));
        run_op(3, 2'b00, 9,  mk(3, 1,  1'b0, 0, 0, 0, 1));
        check("sat_held", 32'(bus.Sat), 32'd0);
        check("result_held", 32'(bus.Result), 32'd1);

        // All four request UP by 1; expect rotation 0,1,2,3,0.
        q.push_back(mk(0, 2, 1'b0, 0, 1, 0, 1));
        q.push_back(mk(1, 3, 1'b0, 0, 1, 0, 1));
        q.push_back(mk(2, 4, 1'b0, 0, 1, 0, 1));
        q.push_back(mk(3, 5, 1'b0, 0, 1, 0, 1));
        q.push_back(mk(0, 6, 1'b0, 0, 1, 0, 1));
        bus.Cmd = {4{2'b10}};
        bus.Arg = {4{5'd1}};
        bus.Req = 4'b1111;
        n = 0;
        for (int t = 0; t < 100 && n < 5; t++) begin
            @(negedge clk);
            if (bus.Done != '0) n++;
        end
        bus.Req = '0;
        check("rr_done_count", 32'(n), 32'd5);
        repeat (3) @(negedge clk);

        // Reset in the middle of UP by 10 after three strobes.
        abort_ok = 1'b1;
        bus.Cmd[3:2] = 2'b10;
        bus.Arg[9:5] = 5'd10;
        bus.Req = 4'b0010;
        @(negedge clk);
        wait_bit(1'b0, 1, 20, "abort_gnt_timeout");
        bus.Req = '0;
        repeat (2) @(negedge clk);
        check("abort_third_strobe", 32'(bus.Cnt_Up), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs",
              32'({bus.Gnt, bus.Done, bus.Sat, bus.Result, bus.Cnt_Load, bus.Cnt_Up, bus.Cnt_Down, bus.Cnt_IN}),
              32'd0);
        rst = 1'b0;
        abort_ok = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_counter", 32'(cnt), 32'd9);

        // After reset the pointer is 0, so requester 0 beats requester 3.
        q.push_back(mk(0, 12, 1'b0, 1, 0, 0, 1));
        bus.Cmd[1:0] = 2'b01; bus.Arg[4:0]   = 5'd12;
        bus.Cmd[7:6] = 2'b01; bus.Arg[19:15] = 5'd20;
        bus.Req = 4'b1001;
        @(negedge clk);
        wait_bit(1'b1, 0, 20, "ptr_done_timeout");
        bus.Req = '0;
        repeat (2) @(negedge clk);

        run_op(3, 2'b11, 15, mk(3, 0, 1'b1, 0, 0, 12, 13));

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
